// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode field encodings and flag-vector bit positions.
package alu_pkg;

  // op[2:1] value that marks an arithmetic operation
  localparam logic [1:0] OP_ARITH = 2'b11;
  // op[0] values selecting adder or subtractor carries
  localparam logic OP_ADD_BIT = 1'b0;
  localparam logic OP_SUB_BIT = 1'b1;

  // Bit positions inside the packed flag vector
  localparam int unsigned FLAG_C    = 0;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_Z    = 2;
  localparam int unsigned FLAG_V    = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/flags_calc.sv
// Combinational C/N/Z/V flag computation for a WIDTH-bit ALU result.
// Optional even-parity output p when ALU_FLAGS_PARITY_EN is defined.
module flags_calc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             co_add,
  input  logic             co_prev_add,
  input  logic             co_sub,
  input  logic             co_prev_sub,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
`ifdef ALU_FLAGS_PARITY_EN
  ,
  output logic             p
`endif
);

  logic is_arith;
  logic is_sub;

  // Carry and overflow only have meaning for arithmetic ops; logic ops force them low.
  always_comb begin
    is_arith = (op[2:1] == OP_ARITH);
    is_sub   = (op[0] == OP_SUB_BIT);
    c = 1'b0;
    v = 1'b0;
    if (is_arith) begin
      if (is_sub) begin
        c = co_sub;
        v = co_sub ^ co_prev_sub;
      end else begin
        c = co_add;
        v = co_add ^ co_prev_add;
      end
    end
    n = result[WIDTH-1];
    z = (result == '0);
  end

`ifdef ALU_FLAGS_PARITY_EN
  // Even parity: 1 when the result has an even number of set bits
  assign p = ~^result;
`endif

endmodule

// File: rtl/alu_flags_reg.sv
// Registered ALU flag stage: computes C/N/Z/V, holds them in a single-entry
// valid/ready output register, and tracks sticky C/V plus a saturating
// overflow-event counter. Define ALU_FLAGS_PARITY_EN to add the parity flag p.
module alu_flags_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             co_add,
  input  logic             co_prev_add,
  input  logic             co_sub,
  input  logic             co_prev_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             sticky_c,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_sticky
`ifdef ALU_FLAGS_PARITY_EN
  ,
  output logic             p
`endif
);

  logic                 c_i, n_i, z_i, v_i;
  logic [NUM_FLAGS-1:0] flags_i;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sticky_c_q, sticky_c_d;
  logic                 sticky_v_q, sticky_v_d;
  logic [CNT_W-1:0]     ovf_cnt_q, ovf_cnt_d;
  logic                 accept;

`ifdef ALU_FLAGS_PARITY_EN
  logic p_i, p_q, p_d;
`endif

  flags_calc #(
    .WIDTH(WIDTH)
  ) u_flags_calc (
    .op         (op),
    .result     (result),
    .co_add     (co_add),
    .co_prev_add(co_prev_add),
    .co_sub     (co_sub),
    .co_prev_sub(co_prev_sub),
    .c          (c_i),
    .n          (n_i),
    .z          (z_i),
    .v          (v_i)
`ifdef ALU_FLAGS_PARITY_EN
    ,
    .p          (p_i)
`endif
  );

  // Pack computed flags; the output register can be refilled in the cycle it drains
  always_comb begin
    flags_i         = '0;
    flags_i[FLAG_C] = c_i;
    flags_i[FLAG_N] = n_i;
    flags_i[FLAG_Z] = z_i;
    flags_i[FLAG_V] = v_i;
    in_ready        = !out_valid_q || out_ready;
    accept          = in_valid && in_ready;
  end

  // Output register next state: load on accept, drop valid once consumed
  always_comb begin
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
`ifdef ALU_FLAGS_PARITY_EN
    p_d         = p_q;
`endif
    if (accept) begin
      flags_d     = flags_i;
      out_valid_d = 1'b1;
`ifdef ALU_FLAGS_PARITY_EN
      p_d         = p_i;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky flags and counter: a same-cycle accept overrides the clear
  always_comb begin
    sticky_c_d = sticky_c_q;
    sticky_v_d = sticky_v_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (accept) begin
      if (clr_sticky) begin
        sticky_c_d = c_i;
        sticky_v_d = v_i;
        ovf_cnt_d  = CNT_W'(v_i);
      end else begin
        sticky_c_d = sticky_c_q | c_i;
        sticky_v_d = sticky_v_q | v_i;
        if (v_i && (ovf_cnt_q != '1)) begin
          ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
      end
    end else if (clr_sticky) begin
      sticky_c_d = 1'b0;
      sticky_v_d = 1'b0;
      ovf_cnt_d  = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      sticky_c_q  <= 1'b0;
      sticky_v_q  <= 1'b0;
      ovf_cnt_q   <= '0;
`ifdef ALU_FLAGS_PARITY_EN
      p_q         <= 1'b0;
`endif
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      sticky_c_q  <= sticky_c_d;
      sticky_v_q  <= sticky_v_d;
      ovf_cnt_q   <= ovf_cnt_d;
`ifdef ALU_FLAGS_PARITY_EN
      p_q         <= p_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign c         = flags_q[FLAG_C];
  assign n         = flags_q[FLAG_N];
  assign z         = flags_q[FLAG_Z];
  assign v         = flags_q[FLAG_V];
  assign sticky_c  = sticky_c_q;
  assign sticky_v  = sticky_v_q;
  assign ovf_cnt   = ovf_cnt_q;
`ifdef ALU_FLAGS_PARITY_EN
  assign p         = p_q;
`endif

endmodule

// File: tb/tb_alu_flags_reg.sv
// Directed self-checking bench for alu_flags_reg (WIDTH=32, CNT_W=3).
// Parity checks are compiled in when ALU_FLAGS_PARITY_EN is defined.
module tb_alu_flags_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] result;
  logic             co_add, co_prev_add, co_sub, co_prev_sub;
  logic             out_valid;
  logic             out_ready;
  logic             c, n, z, v;
  logic             sticky_c, sticky_v;
  logic [CNT_W-1:0] ovf_cnt;
  logic             clr_sticky;
`ifdef ALU_FLAGS_PARITY_EN
  logic             p;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_flags_reg #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .result     (result),
    .co_add     (co_add),
    .co_prev_add(co_prev_add),
    .co_sub     (co_sub),
    .co_prev_sub(co_prev_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c          (c),
    .n          (n),
    .z          (z),
    .v          (v),
    .sticky_c   (sticky_c),
    .sticky_v   (sticky_v),
    .ovf_cnt    (ovf_cnt),
    .clr_sticky (clr_sticky)
`ifdef ALU_FLAGS_PARITY_EN
    ,
    .p          (p)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one operation with in_valid high; caller advances the clock
  task automatic set_op(input logic [2:0] o, input logic [31:0] r, input logic ca,
                        input logic cpa, input logic cs, input logic cps);
    in_valid    = 1'b1;
    op          = o;
    result      = r;
    co_add      = ca;
    co_prev_add = cpa;
    co_sub      = cs;
    co_prev_sub = cps;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic ec, input logic en,
                             input logic ez, input logic ev);
    check_eq({tag, ".c"}, 32'(c), 32'(ec));
    check_eq({tag, ".n"}, 32'(n), 32'(en));
    check_eq({tag, ".z"}, 32'(z), 32'(ez));
    check_eq({tag, ".v"}, 32'(v), 32'(ev));
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    set_op(3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) tick();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_ovf_cnt", 32'(ovf_cnt), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    reset_n = 1'b1;
    tick();

    // Add overflow: 0x7fffffff + 1 style carries
    set_op(3'b110, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check_eq("add_ovf_valid", 32'(out_valid), 1);
    check_flags("add_ovf", 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("add_ovf_sticky_v", 32'(sticky_v), 1);
    check_eq("add_ovf_sticky_c", 32'(sticky_c), 0);
    check_eq("add_ovf_cnt", 32'(ovf_cnt), 1);
    tick();
    check_eq("drain_valid", 32'(out_valid), 0);

    // Subtract to zero, then the same result through a logic op, back to back
    set_op(3'b111, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_flags("sub_zero", 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("sub_zero_sticky_c", 32'(sticky_c), 1);
    set_op(3'b010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    check_eq("logic_zero_valid", 32'(out_valid), 1);
    check_flags("logic_zero", 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("logic_zero_cnt", 32'(ovf_cnt), 1);

    // Clear without accept: stickies drop, held flags untouched
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check_eq("clr_sticky_c", 32'(sticky_c), 0);
    check_eq("clr_sticky_v", 32'(sticky_v), 0);
    check_eq("clr_cnt", 32'(ovf_cnt), 0);
    check_eq("clr_keeps_z", 32'(z), 1);

    // Backpressure: A accepted, B must wait until out_ready returns
    out_ready = 1'b0;
    set_op(3'b110, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("bp_a_valid", 32'(out_valid), 1);
    set_op(3'b111, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready", 32'(in_ready), 0);
      check_flags("bp_hold", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_eq("bp_sticky_v", 32'(sticky_v), 0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_comb", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check_eq("bp_b_valid", 32'(out_valid), 1);
    check_flags("bp_b", 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("bp_sticky_c", 32'(sticky_c), 1);
    check_eq("bp_cnt", 32'(ovf_cnt), 1);
    tick();
    check_eq("bp_drain", 32'(out_valid), 0);

    // Saturation with CNT_W=3
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      set_op(3'b110, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_eq($sformatf("sat_cnt_%0d", i), 32'(ovf_cnt), (i < 7) ? i : 7);
    end
    check_eq("sat_sticky_c", 32'(sticky_c), 0);
    // Clear with an accept: new transaction wins
    clr_sticky = 1'b1;
    set_op(3'b111, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("clr_acc_cnt", 32'(ovf_cnt), 1);
    check_eq("clr_acc_sticky_v", 32'(sticky_v), 1);
    check_eq("clr_acc_sticky_c", 32'(sticky_c), 1);
    set_op(3'b001, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    clr_sticky = 1'b0;
    in_valid   = 1'b0;
    check_eq("clr_logic_cnt", 32'(ovf_cnt), 0);
    check_eq("clr_logic_sticky_c", 32'(sticky_c), 0);
    check_flags("logic_op", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_FLAGS_PARITY_EN
    set_op(3'b000, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("parity_3", 32'(p), 1);
    set_op(3'b000, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check_eq("parity_7", 32'(p), 0);
`endif

    // Reset mid-transfer while out_valid is held under backpressure
    out_ready = 1'b0;
    set_op(3'b110, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("pre_rst_valid", 32'(out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 0);
    check_eq("async_rst_flags", 32'({c, n, z, v}), 0);
    check_eq("async_rst_sticky", 32'({sticky_c, sticky_v}), 0);
    check_eq("async_rst_cnt", 32'(ovf_cnt), 0);
    in_valid = 1'b0;
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flags_reg.md
Name: alu_flags_reg

Overview:
- Parametrised, registered successor to the 32-bit flag calculator. Computes C/N/Z/V for a WIDTH-bit ALU result and holds them in a single-entry output register with valid/ready handshake.
- Maintains sticky carry/overflow flags and a saturating overflow-event counter.
- Sits between the ALU datapath and the status/register-file write-back stage.

Parameters:
- WIDTH, 32, ALU result width in bits; legal range >= 2.
- CNT_W, 8, width of the overflow-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation result present on inputs.
- in_ready  output  1  block can accept this cycle.
- op  input  3  ALU opcode. op[2:1]==2'b11 is arithmetic; op[0]=0 is add, op[0]=1 is subtract.
- result  input  WIDTH  ALU result.
- co_add, co_prev_add  input  1 each  carry out of MSB and out of bit WIDTH-2, adder path.
- co_sub, co_prev_sub  input  1 each  same two carries, subtractor path.
- out_valid  output  1  registered flags valid.
- out_ready  input  1  consumer accepts flags.
- c, n, z, v  output  1 each  registered flags.
- sticky_c, sticky_v  output  1 each  OR-accumulated C and V since the last clear.
- ovf_cnt  output  CNT_W  saturating count of accepted transactions with v=1.
- clr_sticky  input  1  synchronous clear of sticky_c, sticky_v and ovf_cnt.

Behaviour:
- Reset (reset_n=0, asynchronous): out_valid, c, n, z, v, sticky_c, sticky_v = 0; ovf_cnt = 0. Reset asserted mid-transfer discards the held entry; no flags are emitted after reset deasserts.
- Flag functions, combinational, evaluated on the inputs:
  - c_i = op[2:1]!=2'b11 ? 0 : (op[0] ? co_sub : co_add)
  - n_i = result[WIDTH-1]
  - z_i = (result == 0)
  - v_i = op[2:1]!=2'b11 ? 0 : (op[0] ? co_sub^co_prev_sub : co_add^co_prev_add)
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational from out_ready, with no bubble on back-to-back transfers.
  - accept = in_valid && in_ready. On accept, c/n/z/v load the computed flags and out_valid is 1 on the next edge. Latency is 1 cycle.
  - Output is consumed when out_valid && out_ready. If no new accept occurs in that cycle, out_valid goes to 0.
  - While out_valid && !out_ready, c/n/z/v are held stable and in_valid is ignored.
- Sticky flags and counter, updated on accept only:
  - sticky_c |= c_i; sticky_v |= v_i.
  - ovf_cnt increments when v_i=1 and saturates at all-ones. It never wraps.
- clr_sticky:
  - Without an accept in the same cycle: sticky flags and ovf_cnt go to 0.
  - Simultaneous with an accept: the new transaction wins. sticky_c = c_i, sticky_v = v_i, ovf_cnt = v_i.
  - clr_sticky does not affect c/n/z/v or out_valid.
- Non-arithmetic ops force c_i = v_i = 0. n and z are still computed.

Optional Feature:
- Macro: ALU_FLAGS_PARITY_EN.
- Defined: adds output port p (1 bit), registered alongside c/n/z/v. p = ~^result (1 when result has even parity); reset value 0.
- Undefined: port p and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/include alu_pkg holds:
  - opcode field constants: OP_ARITH=2'b11, OP_ADD_BIT=0, OP_SUB_BIT=1;
  - flag-vector bit indices FLAG_C=0, FLAG_N=1, FLAG_Z=2, FLAG_V=3.
- Sub-module flags_calc: purely combinational, parametrised by WIDTH, produces c_i/n_i/z_i/v_i (and p_i when the macro is defined).
- alu_flags_reg instantiates flags_calc and owns all registers and handshake logic.

Test Plan:
- Reset: assert reset_n=0 mid-transfer with out_valid=1 -> all outputs 0 asynchronously; no out_valid after release.
- Add overflow, WIDTH=32, out_ready=1: op=3'b110, result=32'h8000_0000, co_add=0, co_prev_add=1, in_valid pulse -> next cycle out_valid=1, c=0, n=1, z=0, v=1; sticky_v=1; ovf_cnt=1.
- Subtract zero: op=3'b111, result=0, co_sub=1, co_prev_sub=1 -> c=1, z=1, v=0, n=0. Same result with op=3'b010 -> c=0, v=0, z=1.
- Backpressure: out_ready=0 for 5 cycles after one accept -> in_ready=0, flags held constant, second in_valid not taken. Then out_ready=1 -> second transaction appears the following cycle.
- Saturation, CNT_W=3: 9 accepted overflow transactions -> ovf_cnt stops at 7. Then clr_sticky together with an overflow accept -> ovf_cnt=1, sticky_v=1, sticky_c=c_i.
- ALU_FLAGS_PARITY_EN defined: result=32'h0000_0003 -> p=1; result=32'h0000_0007 -> p=0.
